// File: rtl/register_a_pkg.sv
// register_a_pkg: shared definitions for the counting-ones data register.
//   REG_A_DEFAULT_WIDTH : default register width
//   ones_w()            : width of a tally able to hold 0..width
//   ctrl_e              : control encoding of {load, sr}
package register_a_pkg;

  localparam int REG_A_DEFAULT_WIDTH = 8;

  function automatic int ones_w(input int width);
    return $clog2(width + 1);
  endfunction

  // Bit 1 is load, bit 0 is sr; both load encodings load.
  typedef enum logic [1:0] {
    HOLD      = 2'b00,
    SHIFT     = 2'b01,
    LOAD      = 2'b10,
    LOAD_PRIO = 2'b11
  } ctrl_e;

endpackage

// File: rtl/register_a_ones_counter.sv
// register_a_ones_counter: tally of ones shifted out of register_a.
// Only exists in builds with REGISTER_A_ONES_COUNTER_EN defined, so the
// default build carries no stray, uninstantiated module.
//   clk    : rising-edge clock
//   rst    : asynchronous active-high reset, clears the tally
//   clr_i  : synchronous clear (operand load)
//   inc_i  : increment by one on this edge
//   ones_o : current tally
`ifdef REGISTER_A_ONES_COUNTER_EN
module register_a_ones_counter #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] ones_o
);

  logic [CNT_W-1:0] ones_q;
  logic [CNT_W-1:0] ones_d;

  // Clear wins over increment; the register owner guarantees inc_i is low
  // whenever clr_i is high anyway. CNT_W covers WIDTH, so no wrap occurs.
  always_comb begin
    ones_d = ones_q;
    if (clr_i) begin
      ones_d = '0;
    end else if (inc_i) begin
      ones_d = ones_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ones_q <= '0;
    end else begin
      ones_q <= ones_d;
    end
  end

  assign ones_o = ones_q;

endmodule
`endif

// File: rtl/register_a.sv
// register_a: load / logical-shift-right data register for the counting-ones
// datapath. Captures an operand, shifts it right one bit per enabled cycle and
// reports whether the bit leaving is a 1 (count_enable) and whether the
// register has emptied (z).
//   data_in      : operand, sampled on an edge with load high
//   load         : parallel load, has priority over sr
//   sr           : shift-right request
//   clk          : rising-edge clock
//   count_enable : the shift on the coming edge removes a 1 (combinational)
//   z            : register contents are zero (combinational)
//   q            : register contents
//   rst          : asynchronous active-high reset
//   ones         : ones tally, only with REGISTER_A_ONES_COUNTER_EN defined
module register_a
  import register_a_pkg::*;
#(
  parameter int WIDTH = REG_A_DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0]          data_in,
  input  logic                      load,
  input  logic                      sr,
  input  logic                      clk,
  output logic                      count_enable,
  output logic                      z,
  output logic [WIDTH-1:0]          q,
  input  logic                      rst
`ifdef REGISTER_A_ONES_COUNTER_EN
  ,
  output logic [ones_w(WIDTH)-1:0]  ones
`endif
);

  ctrl_e            ctrl;
  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;

  assign ctrl = ctrl_e'({load, sr});

  always_comb begin
    q_d = q_q;
    case (ctrl)
      SHIFT:           q_d = {1'b0, q_q[WIDTH-1:1]};
      LOAD, LOAD_PRIO: q_d = data_in;
      default:         q_d = q_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  // Only a pure shift removes a bit; a load (even with sr) counts nothing.
  assign count_enable = (ctrl == SHIFT) && q_q[0];
  assign z            = ~|q_q;
  assign q            = q_q;

`ifdef REGISTER_A_ONES_COUNTER_EN
  register_a_ones_counter #(
    .CNT_W (ones_w(WIDTH))
  ) u_ones_counter (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (load),
    .inc_i  (count_enable),
    .ones_o (ones)
  );
`endif

endmodule

// File: tb/tb_register_a.sv
module tb_register_a;

  localparam int W = 8;

  logic [W-1:0] data_in;
  logic         load;
  logic         sr;
  logic         clk;
  logic         count_enable;
  logic         z;
  logic [W-1:0] q;
  logic         rst;
`ifdef REGISTER_A_ONES_COUNTER_EN
  logic [3:0]   ones;
`endif

  register_a #(.WIDTH(W)) dut (
    .data_in      (data_in),
    .load         (load),
    .sr           (sr),
    .clk          (clk),
    .count_enable (count_enable),
    .z            (z),
    .q            (q),
    .rst          (rst)
`ifdef REGISTER_A_ONES_COUNTER_EN
    ,
    .ones         (ones)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass;
  int n_total;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic edge_settle();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic         ld;
    logic         s;
    logic [W-1:0] din;
    logic         ce;    // count_enable before the edge
    logic [W-1:0] q;     // q after the edge
    logic         z;     // z after the edge
    logic [3:0]   ones;  // tally after the edge
  } vec_t;

  vec_t vecs[16];

  initial begin
    n_pass  = 0;
    n_total = 0;

    // load B6, shift it out, over-shift, priority load, load 2D, hold
    vecs[0]  = '{1'b1, 1'b0, 8'hB6, 1'b0, 8'hB6, 1'b0, 4'd0};
    vecs[1]  = '{1'b0, 1'b1, 8'h00, 1'b0, 8'h5B, 1'b0, 4'd0};
    vecs[2]  = '{1'b0, 1'b1, 8'h00, 1'b1, 8'h2D, 1'b0, 4'd1};
    vecs[3]  = '{1'b0, 1'b1, 8'h00, 1'b1, 8'h16, 1'b0, 4'd2};
    vecs[4]  = '{1'b0, 1'b1, 8'h00, 1'b0, 8'h0B, 1'b0, 4'd2};
    vecs[5]  = '{1'b0, 1'b1, 8'h00, 1'b1, 8'h05, 1'b0, 4'd3};
    vecs[6]  = '{1'b0, 1'b1, 8'h00, 1'b1, 8'h02, 1'b0, 4'd4};
    vecs[7]  = '{1'b0, 1'b1, 8'h00, 1'b0, 8'h01, 1'b0, 4'd4};
    vecs[8]  = '{1'b0, 1'b1, 8'h00, 1'b1, 8'h00, 1'b1, 4'd5};
    vecs[9]  = '{1'b0, 1'b1, 8'h00, 1'b0, 8'h00, 1'b1, 4'd5};
    vecs[10] = '{1'b0, 1'b1, 8'h00, 1'b0, 8'h00, 1'b1, 4'd5};
    vecs[11] = '{1'b1, 1'b1, 8'hFF, 1'b0, 8'hFF, 1'b0, 4'd0};
    vecs[12] = '{1'b1, 1'b0, 8'h2D, 1'b0, 8'h2D, 1'b0, 4'd0};
    vecs[13] = '{1'b0, 1'b0, 8'hAA, 1'b0, 8'h2D, 1'b0, 4'd0};
    vecs[14] = '{1'b0, 1'b0, 8'h55, 1'b0, 8'h2D, 1'b0, 4'd0};
    vecs[15] = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h2D, 1'b0, 4'd0};

    // Reset held while a load is requested
    rst     = 1'b1;
    load    = 1'b1;
    sr      = 1'b0;
    data_in = 8'hB6;
    edge_settle();
    edge_settle();
    chk("reset_q", 32'(q), 32'h00);
    chk("reset_z", 32'(z), 32'h1);
    chk("reset_ce", 32'(count_enable), 32'h0);
`ifdef REGISTER_A_ONES_COUNTER_EN
    chk("reset_ones", 32'(ones), 32'h0);
`endif
    load = 1'b0;
    rst  = 1'b0;
    edge_settle();

    for (int i = 0; i < 16; i++) begin
      load    = vecs[i].ld;
      sr      = vecs[i].s;
      data_in = vecs[i].din;
      #1;
      chk($sformatf("vec%0d_ce", i), 32'(count_enable), 32'(vecs[i].ce));
      edge_settle();
      chk($sformatf("vec%0d_q", i), 32'(q), 32'(vecs[i].q));
      chk($sformatf("vec%0d_z", i), 32'(z), 32'(vecs[i].z));
`ifdef REGISTER_A_ONES_COUNTER_EN
      chk($sformatf("vec%0d_ones", i), 32'(ones), 32'(vecs[i].ones));
`endif
    end

    // Async reset pulse between edges, q holds 0x2D
    load = 1'b0;
    sr   = 1'b0;
    #1;
    rst = 1'b1;
    #1;
    chk("async_rst_q", 32'(q), 32'h00);
    chk("async_rst_z", 32'(z), 32'h1);
    rst = 1'b0;
    #1;
    chk("async_rel_q", 32'(q), 32'h00);

    // Operand 0x80: seven zero bits, then the single one
    load    = 1'b1;
    data_in = 8'h80;
    edge_settle();
    chk("ld80_q", 32'(q), 32'h80);
    load = 1'b0;
    sr   = 1'b1;
    for (int k = 0; k < 8; k++) begin
      #1;
      chk($sformatf("s80_ce%0d", k), 32'(count_enable), (k == 7) ? 32'h1 : 32'h0);
      chk($sformatf("s80_z%0d", k), 32'(z), 32'h0);
      edge_settle();
    end
    chk("s80_q_end", 32'(q), 32'h00);
    chk("s80_z_end", 32'(z), 32'h1);
`ifdef REGISTER_A_ONES_COUNTER_EN
    chk("s80_ones", 32'(ones), 32'h1);
`endif

    // Operand 0x00: empty immediately
    sr      = 1'b0;
    load    = 1'b1;
    data_in = 8'h5A;
    edge_settle();
    chk("ld5A_z", 32'(z), 32'h0);
    data_in = 8'h00;
    edge_settle();
    chk("ld00_q", 32'(q), 32'h00);
    chk("ld00_z", 32'(z), 32'h1);
    load = 1'b0;
    sr   = 1'b1;
    #1;
    chk("ld00_ce", 32'(count_enable), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
